if_neuron_sequencer: RTL and testbench

Control-side initiator for one integrate-and-fire accumulator neuron. It sequences one neuron update in this order:
- Fetch the neuron's stored membrane voltage from voltage memory and load it into the neuron (`load_en`).
- Stream N activation/weight (or difference) beats into the neuron (`input_valid`).
- Fire the neuron (`output_en`).
- Write the post-fire voltage back to memory and emit a spike event if the neuron fired.

It sits between the layer scheduler (start/done), the input beat FIFO, the voltage RAM and the neuron datapath.

---
 rtl/if_neuron_sequencer.sv | 151 +++++++++++++++
 tb/tb_if_neuron_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_neuron_sequencer.sv
// Sequencer for one integrate-and-fire neuron update:
// read voltage, load, stream N beats, fire, write back and emit the spike event.
module if_neuron_sequencer #(
    parameter int N_INPUTS = 16,
    parameter int IDX_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] neuron_idx,
    input  logic             arithm_mode,
    output logic             busy,
    output logic             done,
    input  logic             beat_valid,
    output logic             beat_ready,
    input  logic [7:0]       beat_act,
    input  logic [7:0]       beat_wt,
    input  logic [15:0]      beat_diff,
    output logic             vmem_rd_en,
    output logic             vmem_wr_en,
    output logic [IDX_W-1:0] vmem_addr,
    input  logic [15:0]      vmem_rd_data,
    output logic [15:0]      vmem_wr_data,
    output logic [7:0]       n_activation,
    output logic [7:0]       n_weight,
    output logic [15:0]      n_diff,
    output logic [15:0]      n_input_mem_vol,
    output logic             n_load_en,
    output logic             n_input_valid,
    output logic             n_output_en,
    output logic             n_arithm,
    input  logic [15:0]      n_out_mem_vol,
    input  logic             n_spike_out,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_idx,
    output logic [2:0]       state_dbg
);

    // Handshake: a beat moves when beat_valid and beat_ready are both high at
    // the rising edge; beat_ready is asserted only in STREAM, so beats that
    // arrive in any other state stay in the FIFO.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_LOAD   = 3'd2,
        S_STREAM = 3'd3,
        S_FIRE   = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(N_INPUTS);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic             mode_q;
    logic [7:0]       cnt_q;
    logic             beat_hs;

    assign beat_hs = (state_q == S_STREAM) && beat_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                idx_q  <= neuron_idx;
                mode_q <= arithm_mode;
            end
            if (state_q == S_LOAD) begin
                cnt_q <= 8'd0;
            end else if (beat_hs) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_RD;
            S_RD:     state_d = S_LOAD;
            S_LOAD:   state_d = S_STREAM;
            // The final handshake goes straight to FIRE, which covers N_INPUTS=1.
            S_STREAM: if (beat_hs && (cnt_q + 8'd1 == LAST_BEAT)) state_d = S_FIRE;
            S_FIRE:   state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        beat_ready    = 1'b0;
        vmem_rd_en    = 1'b0;
        vmem_wr_en    = 1'b0;
        vmem_wr_data  = 16'd0;
        n_load_en     = 1'b0;
        n_input_valid = 1'b0;
        n_output_en   = 1'b0;
        n_arithm      = 1'b0;
        spike_valid   = 1'b0;
        case (state_q)
            S_RD: begin
                busy       = 1'b1;
                vmem_rd_en = 1'b1;
            end
            S_LOAD: begin
                busy      = 1'b1;
                n_load_en = 1'b1;
                n_arithm  = mode_q;
            end
            S_STREAM: begin
                busy          = 1'b1;
                beat_ready    = 1'b1;
                n_input_valid = beat_valid;
                n_arithm      = mode_q;
            end
            S_FIRE: begin
                busy        = 1'b1;
                n_output_en = 1'b1;
                n_arithm    = mode_q;
            end
            S_WB: begin
                busy         = 1'b1;
                done         = 1'b1;
                vmem_wr_en   = 1'b1;
                vmem_wr_data = n_out_mem_vol;
                spike_valid  = n_spike_out;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign vmem_addr       = idx_q;
    assign spike_idx       = idx_q;
    assign n_activation    = beat_act;
    assign n_weight        = beat_wt;
    assign n_diff          = beat_diff;
    assign n_input_mem_vol = vmem_rd_data;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_if_neuron_sequencer.sv
// Bench for if_neuron_sequencer: voltage RAM and threshold-127 neuron models,
// table vectors, randomized jobs against a reference, and hand-written corner cases.
module tb_if_neuron_sequencer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic [7:0]  neuron_idx = '0;
    logic        arithm_mode = 1'b0;
    logic        beat_valid = 1'b0;
    logic [7:0]  beat_act = '0;
    logic [7:0]  beat_wt = '0;
    logic [15:0] beat_diff = '0;
    logic [15:0] vmem_rd_data = '0;
    logic [15:0] n_out_mem_vol = '0;
    logic        n_spike_out = 1'b0;

    logic        busy, done, beat_ready, vmem_rd_en, vmem_wr_en;
    logic [7:0]  vmem_addr, spike_idx, n_activation, n_weight;
    logic [15:0] vmem_wr_data, n_diff, n_input_mem_vol;
    logic        n_load_en, n_input_valid, n_output_en, n_arithm, spike_valid;
    logic [2:0]  state_dbg;

    logic        busy_1, done_1, beat_ready_1, vmem_rd_en_1, vmem_wr_en_1;
    logic [7:0]  vmem_addr_1, spike_idx_1, n_activation_1, n_weight_1;
    logic [15:0] vmem_wr_data_1, n_diff_1, n_input_mem_vol_1;
    logic        n_load_en_1, n_input_valid_1, n_output_en_1, n_arithm_1, spike_valid_1;
    logic [2:0]  state_dbg_1;

    if_neuron_sequencer #(.N_INPUTS(N), .IDX_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .neuron_idx(neuron_idx),
        .arithm_mode(arithm_mode), .busy(busy), .done(done),
        .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_act(beat_act), .beat_wt(beat_wt), .beat_diff(beat_diff),
        .vmem_rd_en(vmem_rd_en), .vmem_wr_en(vmem_wr_en), .vmem_addr(vmem_addr),
        .vmem_rd_data(vmem_rd_data), .vmem_wr_data(vmem_wr_data),
        .n_activation(n_activation), .n_weight(n_weight), .n_diff(n_diff),
        .n_input_mem_vol(n_input_mem_vol), .n_load_en(n_load_en),
        .n_input_valid(n_input_valid), .n_output_en(n_output_en), .n_arithm(n_arithm),
        .n_out_mem_vol(n_out_mem_vol), .n_spike_out(n_spike_out),
        .spike_valid(spike_valid), .spike_idx(spike_idx), .state_dbg(state_dbg)
    );

    // Single-beat instance, used only for its control timing.
    if_neuron_sequencer #(.N_INPUTS(1), .IDX_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .neuron_idx(neuron_idx),
        .arithm_mode(arithm_mode), .busy(busy_1), .done(done_1),
        .beat_valid(beat_valid), .beat_ready(beat_ready_1),
        .beat_act(beat_act), .beat_wt(beat_wt), .beat_diff(beat_diff),
        .vmem_rd_en(vmem_rd_en_1), .vmem_wr_en(vmem_wr_en_1), .vmem_addr(vmem_addr_1),
        .vmem_rd_data(vmem_rd_data), .vmem_wr_data(vmem_wr_data_1),
        .n_activation(n_activation_1), .n_weight(n_weight_1), .n_diff(n_diff_1),
        .n_input_mem_vol(n_input_mem_vol_1), .n_load_en(n_load_en_1),
        .n_input_valid(n_input_valid_1), .n_output_en(n_output_en_1), .n_arithm(n_arithm_1),
        .n_out_mem_vol(n_out_mem_vol), .n_spike_out(n_spike_out),
        .spike_valid(spike_valid_1), .spike_idx(spike_idx_1), .state_dbg(state_dbg_1)
    );

    always #5 clk = ~clk;

    // ---------------- environment: voltage RAM and neuron ----------------
    logic [15:0] vmem [256];
    logic [15:0] acc = '0;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (pl_en) vmem[pl_addr] <= pl_data;
        else if (vmem_wr_en) vmem[vmem_addr] <= vmem_wr_data;
        if (vmem_rd_en) vmem_rd_data <= vmem[vmem_addr];
        if (n_load_en) acc <= n_input_mem_vol;
        else if (n_input_valid) acc <= acc + (n_arithm ? n_diff : 16'(n_activation * n_weight));
        if (n_output_en) begin
            if ($signed(acc) > 127) begin
                n_spike_out   <= 1'b1;
                n_out_mem_vol <= acc - 16'd127;
            end else begin
                n_spike_out   <= 1'b0;
                n_out_mem_vol <= acc;
            end
        end
    end

    always @(negedge clk) if (vmem_wr_en) wr_cnt <= wr_cnt + 1;

    // ---------------- scoreboard helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [41:0] outs0();
        return {busy, done, beat_ready, vmem_rd_en, vmem_wr_en, n_load_en, n_input_valid,
                n_output_en, n_arithm, spike_valid, vmem_addr, spike_idx, vmem_wr_data};
    endfunction

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0]  b_act [N];
    logic [7:0]  b_wt  [N];
    logic [15:0] b_diff[N];

    task automatic put_beat(input int j);
        beat_act = b_act[j]; beat_wt = b_wt[j]; beat_diff = b_diff[j];
    endtask

    int          r_done, r_iv;
    logic [15:0] r_wr;
    logic        r_spk;
    logic [7:0]  r_sidx;

    // Runs one update starting in the current cycle (cycle 0) and checks every
    // cycle's strobes against the ideal timeline; returns just after the
    // edge that follows WB, so a following call is back-to-back.
    task automatic run_job(input logic [7:0] idx, input logic mode, input int stall_at,
                           input int stall_len, input int ign_at);
        int s_exp, fire_r, wb_r, sent, stalled;
        logic in_stream, exp_busy;
        logic [9:0] ev, gv;
        s_exp  = (stall_at < N) ? stall_len : 0;
        fire_r = N + 3 + s_exp;
        wb_r   = N + 4 + s_exp;
        sent = 0; stalled = 0;
        r_done = -1; r_iv = 0; r_wr = '0; r_spk = 1'b0; r_sidx = '0;
        start = 1'b1; neuron_idx = idx; arithm_mode = mode; beat_valid = 1'b0;
        for (int r = 0; r < wb_r + 20; r++) begin
            @(negedge clk);
            in_stream = (r >= 3) && (r <= N + 2 + s_exp);
            exp_busy  = (r >= 1) && (r <= wb_r);
            ev = {exp_busy, r == wb_r, r == 1, r == wb_r, r == 2, in_stream,
                  in_stream && beat_valid, r == fire_r, mode && (r >= 2) && (r <= fire_r),
                  (r == wb_r) && n_spike_out};
            gv = {busy, done, vmem_rd_en, vmem_wr_en, n_load_en, beat_ready, n_input_valid,
                  n_output_en, n_arithm, spike_valid};
            check($sformatf("strobes_idx%0d_r%0d", idx, r), {gv, exp_busy ? vmem_addr : 8'h0},
                  {ev, exp_busy ? idx : 8'h0});
            if (beat_valid && beat_ready) sent++;
            if (n_input_valid) r_iv++;
            if (done) begin
                r_done = r; r_wr = vmem_wr_data; r_spk = spike_valid; r_sidx = spike_idx;
            end
            @(posedge clk); #1;
            start = (r + 1 == ign_at);
            if (start) begin neuron_idx = 8'd5; arithm_mode = ~mode; end
            if (r_done >= 0) break;
            if (r + 1 <= 2) begin
                beat_valid = 1'b1; put_beat(0);
            end else if (sent < N) begin
                if (sent == stall_at && stalled < stall_len) begin
                    beat_valid = 1'b0; stalled++;
                end else begin
                    beat_valid = 1'b1; put_beat(sent);
                end
            end else begin
                beat_valid = 1'b0;
            end
        end
        if (r_done < 0) begin
            checks++; errors++;
            $display("FAIL job_timeout idx=%0d got=no_done exp=done", idx);
        end
        start = 1'b0; beat_valid = 1'b0;
    endtask

    task automatic check_job(input string tag, input logic [7:0] idx, input int exp_done,
                             input logic [15:0] exp_wr, input logic exp_spk);
        check({tag, "_done_cycle"}, 64'(r_done), 64'(exp_done));
        check({tag, "_wr_data"}, r_wr, exp_wr);
        check({tag, "_spike"}, r_spk, exp_spk);
        check({tag, "_spike_idx"}, r_sidx, idx);
        check({tag, "_beats"}, 64'(r_iv), 64'(N));
        check({tag, "_vmem"}, vmem[idx], exp_wr);
    endtask

    typedef struct {
        logic [7:0]  idx;
        logic        mode;
        logic [15:0] vinit;
        logic [7:0]  act;
        logic [7:0]  wt;
        logic [15:0] diff;
        int          stall_at;
        int          stall_len;
        logic [15:0] exp_wr;
        logic        exp_spk;
        int          exp_done;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, hs;
        tbl[0] = '{8'd3,   1'b0, 16'd10,  8'd1, 8'd30, 16'h0100, 0, 0, 16'd3,   1'b1, 8};
        tbl[1] = '{8'd3,   1'b0, 16'd10,  8'd1, 8'd20, 16'h0100, 0, 0, 16'd90,  1'b0, 8};
        tbl[2] = '{8'd3,   1'b0, 16'd10,  8'd1, 8'd30, 16'h0000, 2, 3, 16'd3,   1'b1, 11};
        tbl[3] = '{8'd0,   1'b1, 16'd0,   8'd3, 8'd3,  16'd40,   0, 0, 16'd33,  1'b1, 8};
        tbl[4] = '{8'd9,   1'b1, 16'd100, 8'd5, 8'd5,  16'hFFF6, 0, 0, 16'd60,  1'b0, 8};
        tbl[5] = '{8'd200, 1'b0, 16'd0,   8'd2, 8'd16, 16'h0000, 0, 2, 16'd1,   1'b1, 10};
        tbl[6] = '{8'd255, 1'b0, 16'd127, 8'd0, 8'd0,  16'h0000, N, 3, 16'd127, 1'b0, 8};

        // reset state
        beat_valid = 1'b1;
        @(negedge clk);
        check("reset_outputs", outs0(), '0);
        check("reset_outputs_n1", {busy_1, done_1, beat_ready_1, n_load_en_1}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1; beat_valid = 1'b0;
        idle(2);

        // table vectors
        for (int t = 0; t < 7; t++) begin
            for (int j = 0; j < N; j++) begin
                b_act[j] = tbl[t].act; b_wt[j] = tbl[t].wt; b_diff[j] = tbl[t].diff;
            end
            preload(tbl[t].idx, tbl[t].vinit);
            run_job(tbl[t].idx, tbl[t].mode, tbl[t].stall_at, tbl[t].stall_len, -1);
            check_job($sformatf("vec%0d", t), tbl[t].idx, tbl[t].exp_done, tbl[t].exp_wr,
                      tbl[t].exp_spk);
            idle(1);
        end

        // ignored start during STREAM, then back-to-back start after WB
        for (int j = 0; j < N; j++) begin b_act[j] = 8'd1; b_wt[j] = 8'd30; b_diff[j] = '0; end
        preload(8'd3, 16'd10);
        preload(8'd5, 16'h1234);
        preload(8'd7, 16'd50);
        wc = wr_cnt;
        run_job(8'd3, 1'b0, N, 0, 5);
        check_job("ign_first", 8'd3, 8, 16'd3, 1'b1);
        run_job(8'd7, 1'b0, N, 0, -1);
        check_job("b2b_second", 8'd7, 8, 16'd43, 1'b1);
        idle(4);
        check("ign_idx5_untouched", vmem[5], 16'h1234);
        check("ign_write_count", 64'(wr_cnt - wc), 64'd2);
        check("ign_idle_after", busy, 1'b0);

        // reset in the middle of STREAM
        preload(8'd4, 16'd77);
        wc = wr_cnt;
        for (int j = 0; j < N; j++) begin b_act[j] = 8'd1; b_wt[j] = 8'd1; end
        start = 1'b1; neuron_idx = 8'd4; arithm_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; beat_valid = 1'b1; put_beat(0);
        hs = 0;
        for (int k = 0; k < 20 && hs < 2; k++) begin
            @(negedge clk);
            if (n_input_valid) hs++;
            if (hs < 2) begin @(posedge clk); #1; end
        end
        check("rst_mid_two_beats", 64'(hs), 64'd2);
        #1 rst_n = 1'b0;
        #1 check("rst_mid_async_outputs", outs0(), '0);
        @(negedge clk);
        check("rst_mid_held_outputs", outs0(), '0);
        @(posedge clk); #1;
        rst_n = 1'b1; beat_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_idle_after", outs0(), '0);
        check("rst_mid_no_write", 64'(wr_cnt - wc), 64'd0);
        check("rst_mid_vmem_kept", vmem[4], 16'd77);
        @(posedge clk); #1;
        for (int j = 0; j < N; j++) begin b_act[j] = 8'd1; b_wt[j] = 8'd30; end
        run_job(8'd4, 1'b0, N, 0, -1);
        check_job("rst_mid_next", 8'd4, 8, 16'd70, 1'b1);
        idle(1);

        // single-beat instance timing
        start1 = 1'b1; beat_valid = 1'b1; put_beat(0);
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            check($sformatf("n1_strobes_r%0d", r),
                  {busy_1, n_load_en_1, beat_ready_1, n_input_valid_1, n_output_en_1, done_1},
                  {(r >= 1) && (r <= 5), r == 2, r == 3, r == 3, r == 4, r == 5});
            @(posedge clk); #1;
            start1 = 1'b0;
        end
        beat_valid = 1'b0;
        check("n1_main_untouched", busy, 1'b0);
        idle(1);

        // randomized jobs against the reference model
        for (int t = 0; t < 16; t++) begin
            logic [7:0]  idx;
            logic        mode;
            int          vinit, v, sa, sl, ds;
            logic [15:0] exp_wr;
            logic        exp_spk;
            idx   = 8'($urandom_range(0, 255));
            mode  = 1'($urandom_range(0, 1));
            vinit = $urandom_range(0, 200);
            sa    = $urandom_range(0, N);
            sl    = $urandom_range(0, 3);
            v     = vinit;
            for (int j = 0; j < N; j++) begin
                b_act[j] = 8'($urandom_range(0, 15));
                b_wt[j]  = 8'($urandom_range(0, 15));
                ds       = $urandom_range(0, 90) - 30;
                b_diff[j] = 16'(ds);
                v += mode ? ds : int'(b_act[j]) * int'(b_wt[j]);
            end
            exp_spk = (v > 127);
            exp_wr  = 16'(exp_spk ? v - 127 : v);
            preload(idx, 16'(vinit));
            run_job(idx, mode, sa, sl, -1);
            check_job($sformatf("rnd%0d", t), idx, N + 4 + ((sa < N) ? sl : 0), exp_wr, exp_spk);
            idle($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
